// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU op sequencer.
// ALU_OP_SEQUENCER_ECHO_EN adds the ECHO sequencer state.
package alu_pkg;

    localparam int unsigned DATA_W        = 32;
    localparam int unsigned BYTE_W        = 8;
    localparam int unsigned LEN_W         = 16;
    localparam int unsigned HDR_BYTES     = 4;
    localparam int unsigned MIN_ARITH_LEN = HDR_BYTES + DATA_W / BYTE_W;

    localparam logic [BYTE_W-1:0] OP_ADD  = 8'h10;
    localparam logic [BYTE_W-1:0] OP_MUL  = 8'h11;
    localparam logic [BYTE_W-1:0] OP_DIV  = 8'h12;
    localparam logic [BYTE_W-1:0] OP_ECHO = 8'hEC;

    typedef enum logic [1:0] {
        UOP_ADD = 2'd0,
        UOP_MUL = 2'd1,
        UOP_DIV = 2'd2
    } unit_op_e;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_HDR1   = 4'd1,
        S_LEN_LO = 4'd2,
        S_LEN_HI = 4'd3,
        S_OPND   = 4'd4,
        S_ISSUE  = 4'd5,
        S_WAIT   = 4'd6,
        S_TX     = 4'd7,
        S_DRAIN  = 4'd8
`ifdef ALU_OP_SEQUENCER_ECHO_EN
        ,
        S_ECHO   = 4'd9
`endif
    } seq_state_e;

    // Packet opcode to unit operation; non-arithmetic opcodes never reach the unit.
    function automatic unit_op_e op_to_uop(input logic [BYTE_W-1:0] opc);
        unit_op_e uop;
        case (opc)
            OP_MUL:  uop = UOP_MUL;
            OP_DIV:  uop = UOP_DIV;
            default: uop = UOP_ADD;
        endcase
        return uop;
    endfunction

endpackage

// File: rtl/alu_seq_word_tx.sv
// 32-bit word to four big-endian bytes with a registered valid/ready output.
module alu_seq_word_tx
    import alu_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_word,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [BYTE_W-1:0] o_data,
    output logic              o_last_c
);

    logic                     r_valid;
    logic [BYTE_W-1:0]        r_data;
    logic [DATA_W-BYTE_W-1:0] r_shift;
    logic [1:0]               r_cnt;

    // Byte 0 is presented on load; each handshake shifts in the next byte.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_shift <= '0;
            r_cnt   <= 2'd0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_word[DATA_W-1 -: BYTE_W];
            r_shift <= i_word[DATA_W-BYTE_W-1:0];
            r_cnt   <= 2'd0;
        end else if (r_valid && i_ready) begin
            if (r_cnt == 2'd3) begin
                r_valid <= 1'b0;
                r_data  <= '0;
            end else begin
                r_data  <= r_shift[DATA_W-BYTE_W-1 -: BYTE_W];
                r_shift <= {r_shift[DATA_W-2*BYTE_W-1:0], BYTE_W'(0)};
                r_cnt   <= r_cnt + 2'd1;
            end
        end
    end

    assign o_valid  = r_valid;
    assign o_data   = r_data;
    assign o_last_c = r_valid && i_ready && (r_cnt == 2'd3);

endmodule

// File: rtl/alu_op_sequencer.sv
// Packet controller folding big-endian operands through the shared iterative unit.
// ALU_OP_SEQUENCER_ECHO_EN enables opcode 0xEC payload echo.
module alu_op_sequencer
    import alu_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [BYTE_W-1:0] data_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic [BYTE_W-1:0] data_o,
    input  logic              ready_i,
    output logic              unit_v_o,
    input  logic              unit_ready_i,
    output logic [1:0]        unit_op_o,
    output logic [DATA_W-1:0] unit_a_o,
    output logic [DATA_W-1:0] unit_b_o,
    input  logic              unit_v_i,
    input  logic [DATA_W-1:0] unit_result_i,
    output logic              unit_yumi_o
);

    seq_state_e               r_state;
    seq_state_e               w_state_next;
    logic [BYTE_W-1:0]        r_opcode;
    logic [BYTE_W-1:0]        r_len_lo;
    logic [LEN_W-1:0]         r_rem;
    logic                     r_first;
    unit_op_e                 r_uop;
    logic [DATA_W-1:0]        r_acc;
    logic [DATA_W-1:0]        r_b;
    logic [DATA_W-BYTE_W-1:0] r_word;

    logic                     w_rx_fire;
    logic [LEN_W-1:0]         w_len;
    logic [LEN_W-1:0]         w_rem;
    logic                     w_len_short;
    logic                     w_is_arith;
    logic                     w_is_echo;
    logic                     w_malformed;
    logic [DATA_W-1:0]        w_word_full;
    logic                     w_word_last;
    logic                     w_tx_load;
    logic [DATA_W-1:0]        w_tx_word;
    logic                     w_tx_valid;
    logic [BYTE_W-1:0]        w_tx_data;
    logic                     w_tx_last;

`ifdef ALU_OP_SEQUENCER_ECHO_EN
    logic                     r_echo_valid;
    logic [BYTE_W-1:0]        r_echo_data;
`endif

    assign w_rx_fire   = valid_i && ready_o;
    assign w_len       = {data_i, r_len_lo};
    assign w_rem       = w_len - LEN_W'(HDR_BYTES);
    assign w_len_short = w_len < LEN_W'(HDR_BYTES);
    assign w_is_arith  = (r_opcode == OP_ADD) || (r_opcode == OP_MUL) || (r_opcode == OP_DIV);
`ifdef ALU_OP_SEQUENCER_ECHO_EN
    assign w_is_echo   = (r_opcode == OP_ECHO);
`else
    assign w_is_echo   = 1'b0;
`endif
    assign w_malformed = w_is_echo ? w_len_short
                                   : (!w_is_arith || (w_len < LEN_W'(MIN_ARITH_LEN)) || (w_rem[1:0] != 2'd0));
    assign w_word_full = {r_word, data_i};
    // Remaining count starts word-aligned, so its low bits mark the 4th byte of a word.
    assign w_word_last = (r_rem[1:0] == 2'd1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_tx_load    = 1'b0;
        w_tx_word    = w_word_full;
        case (r_state)
            S_IDLE:   if (w_rx_fire) w_state_next = S_HDR1;
            S_HDR1:   if (w_rx_fire) w_state_next = S_LEN_LO;
            S_LEN_LO: if (w_rx_fire) w_state_next = S_LEN_HI;
            S_LEN_HI: begin
                if (w_rx_fire) begin
                    if (w_malformed)
                        w_state_next = (w_len_short || (w_rem == '0)) ? S_IDLE : S_DRAIN;
`ifdef ALU_OP_SEQUENCER_ECHO_EN
                    else if (w_is_echo)
                        w_state_next = (w_rem == '0) ? S_IDLE : S_ECHO;
`endif
                    else
                        w_state_next = S_OPND;
                end
            end
            S_OPND: begin
                if (w_rx_fire && w_word_last) begin
                    if (!r_first) begin
                        w_state_next = S_ISSUE;
                    end else if (r_rem == LEN_W'(1)) begin
                        w_state_next = S_TX;
                        w_tx_load    = 1'b1;
                    end
                end
            end
            S_ISSUE:  if (unit_ready_i) w_state_next = S_WAIT;
            S_WAIT: begin
                if (unit_v_i) begin
                    w_tx_word = unit_result_i;
                    if (r_rem == '0) begin
                        w_state_next = S_TX;
                        w_tx_load    = 1'b1;
                    end else begin
                        w_state_next = S_OPND;
                    end
                end
            end
            S_TX:     if (w_tx_last) w_state_next = S_IDLE;
            S_DRAIN:  if (w_rx_fire && (r_rem == LEN_W'(1))) w_state_next = S_IDLE;
`ifdef ALU_OP_SEQUENCER_ECHO_EN
            S_ECHO:   if ((r_rem == '0) && !r_echo_valid) w_state_next = S_IDLE;
`endif
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Header fields, operand assembly and accumulator.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_opcode <= '0;
            r_len_lo <= '0;
            r_rem    <= '0;
            r_first  <= 1'b0;
            r_uop    <= UOP_ADD;
            r_acc    <= '0;
            r_b      <= '0;
            r_word   <= '0;
        end else begin
            case (r_state)
                S_IDLE:   if (w_rx_fire) r_opcode <= data_i;
                S_LEN_LO: if (w_rx_fire) r_len_lo <= data_i;
                S_LEN_HI: begin
                    if (w_rx_fire) begin
                        r_rem   <= w_len_short ? '0 : w_rem;
                        r_first <= 1'b1;
                        r_uop   <= op_to_uop(r_opcode);
                    end
                end
                S_OPND: begin
                    if (w_rx_fire) begin
                        r_rem  <= r_rem - LEN_W'(1);
                        r_word <= w_word_full[DATA_W-BYTE_W-1:0];
                        if (w_word_last) begin
                            if (r_first) begin
                                r_acc   <= w_word_full;
                                r_first <= 1'b0;
                            end else begin
                                r_b     <= w_word_full;
                            end
                        end
                    end
                end
                S_WAIT:   if (unit_v_i) r_acc <= unit_result_i;
                S_DRAIN:  if (w_rx_fire) r_rem <= r_rem - LEN_W'(1);
`ifdef ALU_OP_SEQUENCER_ECHO_EN
                S_ECHO:   if (w_rx_fire) r_rem <= r_rem - LEN_W'(1);
`endif
                default: ;
            endcase
        end
    end

`ifdef ALU_OP_SEQUENCER_ECHO_EN
    // One-entry echo buffer; RX is stalled while it holds a byte.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_echo_valid <= 1'b0;
            r_echo_data  <= '0;
        end else if ((r_state == S_ECHO) && w_rx_fire) begin
            r_echo_valid <= 1'b1;
            r_echo_data  <= data_i;
        end else if (r_echo_valid && ready_i) begin
            r_echo_valid <= 1'b0;
            r_echo_data  <= '0;
        end
    end
`endif

    always_comb begin
        ready_o = 1'b0;
        case (r_state)
            S_IDLE, S_HDR1, S_LEN_LO, S_LEN_HI, S_OPND, S_DRAIN: ready_o = 1'b1;
`ifdef ALU_OP_SEQUENCER_ECHO_EN
            S_ECHO:  ready_o = !r_echo_valid;
`endif
            default: ready_o = 1'b0;
        endcase
    end

    alu_seq_word_tx u_word_tx (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .i_load   (w_tx_load),
        .i_word   (w_tx_word),
        .i_ready  (ready_i),
        .o_valid  (w_tx_valid),
        .o_data   (w_tx_data),
        .o_last_c (w_tx_last)
    );

`ifdef ALU_OP_SEQUENCER_ECHO_EN
    assign valid_o = w_tx_valid | r_echo_valid;
    assign data_o  = w_tx_data | r_echo_data;
`else
    assign valid_o = w_tx_valid;
    assign data_o  = w_tx_data;
`endif

    assign unit_v_o    = (r_state == S_ISSUE);
    assign unit_op_o   = r_uop;
    assign unit_a_o    = r_acc;
    assign unit_b_o    = r_b;
    assign unit_yumi_o = (r_state == S_WAIT) && unit_v_i;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a behavioural arithmetic unit.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    typedef logic [7:0]  bq_t[$];
    typedef logic [31:0] wq_t[$];
    typedef struct packed {logic [1:0] op; logic [31:0] a; logic [31:0] b;} iss_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [7:0]  data_i;
    logic        ready_o;
    logic        valid_o;
    logic [7:0]  data_o;
    logic        ready_i;
    logic        unit_v_o;
    logic        unit_ready_i;
    logic [1:0]  unit_op_o;
    logic [31:0] unit_a_o;
    logic [31:0] unit_b_o;
    logic        unit_v_i;
    logic [31:0] unit_result_i;
    logic        unit_yumi_o;

    int   tests_run = 0;
    int   tests_failed = 0;
    int   u_hold = 0;
    int   tx_hold = 0;
    int   stab_err = 0;
    bit   timed_out = 0;
    logic [7:0] rx_q[$];
    iss_t iss_q[$];

    int   u_phase = 0, u_cnt = 0, u_hcnt = 0, t_hcnt = 0;
    logic [31:0] u_res = 0;
    bit   u_fire, u_yumi, u_prev_v = 0, u_prev_fire = 0;
    iss_t u_prev = '0;
    bit   t_fire, t_prev_v = 0, t_prev_fire = 0;
    logic [7:0] t_prev_d = 0;

    always #5 clk_i = ~clk_i;

    alu_op_sequencer dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .data_i(data_i), .ready_o(ready_o),
        .valid_o(valid_o), .data_o(data_o), .ready_i(ready_i), .unit_v_o(unit_v_o),
        .unit_ready_i(unit_ready_i), .unit_op_o(unit_op_o), .unit_a_o(unit_a_o), .unit_b_o(unit_b_o),
        .unit_v_i(unit_v_i), .unit_result_i(unit_result_i), .unit_yumi_o(unit_yumi_o)
    );

    function automatic logic [31:0] unit_calc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a * b;
            2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return 32'h0;
        endcase
    endfunction

    // Behavioural unit: optional accept stall, random latency, hold result until yumi.
    initial begin
        unit_ready_i = 1'b1; unit_v_i = 1'b0; unit_result_i = '0;
        forever begin
            @(negedge clk_i);
            if (!rst_i && u_prev_v && !u_prev_fire && (!unit_v_o || {unit_op_o, unit_a_o, unit_b_o} !== u_prev))
                stab_err++;
            u_fire = unit_v_o && unit_ready_i;
            u_yumi = unit_yumi_o;
            if (u_fire) begin
                iss_q.push_back({unit_op_o, unit_a_o, unit_b_o});
                u_res = unit_calc(unit_op_o, unit_a_o, unit_b_o);
            end
            u_prev_v = unit_v_o; u_prev_fire = u_fire; u_prev = {unit_op_o, unit_a_o, unit_b_o};
            @(posedge clk_i); #1;
            if (rst_i) begin
                u_phase = 0; u_hcnt = 0; unit_v_i = 1'b0; unit_ready_i = (u_hold == 0);
                continue;
            end
            case (u_phase)
                0: if (u_fire) begin
                       u_phase = 1; u_cnt = $urandom_range(0, 3); unit_ready_i = 1'b0;
                   end else if (unit_v_o) begin
                       if (u_hcnt >= u_hold) unit_ready_i = 1'b1;
                       else begin unit_ready_i = 1'b0; u_hcnt++; end
                   end else begin
                       unit_ready_i = (u_hold == 0); u_hcnt = 0;
                   end
                1: if (u_cnt == 0) begin unit_v_i = 1'b1; unit_result_i = u_res; u_phase = 2; end
                   else u_cnt--;
                default: if (u_yumi) begin
                       unit_v_i = 1'b0; unit_result_i = $urandom; u_phase = 0; u_hcnt = 0;
                       unit_ready_i = (u_hold == 0);
                   end
            endcase
        end
    end

    // TX sink: collects bytes, applies per-byte backpressure, watches stability.
    initial begin
        ready_i = 1'b1;
        forever begin
            @(negedge clk_i);
            if (!rst_i && t_prev_v && !t_prev_fire && (!valid_o || data_o !== t_prev_d)) stab_err++;
            t_fire = valid_o && ready_i;
            if (t_fire) rx_q.push_back(data_o);
            t_prev_v = valid_o; t_prev_fire = t_fire; t_prev_d = data_o;
            @(posedge clk_i); #1;
            if (t_fire) t_hcnt = 0;
            if (valid_o && !rst_i) begin
                if (t_hcnt >= tx_hold) ready_i = 1'b1;
                else begin ready_i = 1'b0; t_hcnt++; end
            end else begin
                ready_i = (tx_hold == 0); t_hcnt = 0;
            end
        end
    end

    function automatic bq_t mk_pkt(input logic [7:0] opc, input wq_t w);
        bq_t q;
        logic [15:0] l16;
        logic [31:0] wd;
        l16 = 16'(4 + 4 * w.size());
        q.push_back(opc); q.push_back(8'h00); q.push_back(l16[7:0]); q.push_back(l16[15:8]);
        foreach (w[i]) begin
            wd = w[i];
            q.push_back(wd[31:24]); q.push_back(wd[23:16]); q.push_back(wd[15:8]); q.push_back(wd[7:0]);
        end
        return q;
    endfunction

    function automatic logic [31:0] fold_ref(input logic [7:0] opc, input wq_t w);
        logic [31:0] acc;
        acc = w[0];
        for (int i = 1; i < w.size(); i++) begin
            if (opc == 8'h10)      acc = acc + w[i];
            else if (opc == 8'h11) acc = acc * w[i];
            else                   acc = acc / w[i];
        end
        return acc;
    endfunction

    function automatic logic [31:0] resp_word();
        if (rx_q.size() != 4) return 32'hxxxx_xxxx;
        return {rx_q[0], rx_q[1], rx_q[2], rx_q[3]};
    endfunction

    task automatic begin_test();
        rx_q.delete(); iss_q.delete(); stab_err = 0; timed_out = 0;
    endtask

    task automatic send_bytes(input bq_t pkt);
        bit acc_ok;
        int n;
        foreach (pkt[i]) begin
            valid_i = 1'b1; data_i = pkt[i]; n = 0;
            do begin
                acc_ok = ready_o;
                @(posedge clk_i); #1;
                n++;
            end while (!acc_ok && n < 300);
            if (!acc_ok) timed_out = 1;
        end
        valid_i = 1'b0; data_i = '0;
    endtask

    task automatic wait_resp(input int nbytes);
        int n = 0;
        while (rx_q.size() < nbytes && n < 3000) begin @(posedge clk_i); #1; n++; end
        if (rx_q.size() < nbytes) timed_out = 1;
        repeat (20) @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; valid_i = 1'b0; data_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        tests_run++; if (ready_o !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
        tests_run++; if ({valid_o, data_o} !== 9'h0) begin tests_failed++; $display("FAIL reset_tx: got %h expected 0", {valid_o, data_o}); end
        tests_run++; if ({unit_v_o, unit_yumi_o, unit_op_o} !== 4'h0) begin tests_failed++; $display("FAIL reset_unit_ctl: got %h expected 0", {unit_v_o, unit_yumi_o, unit_op_o}); end
        tests_run++; if ({unit_a_o, unit_b_o} !== 64'h0) begin tests_failed++; $display("FAIL reset_operands: got %h expected 0", {unit_a_o, unit_b_o}); end
        rst_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    task automatic test_add();
        u_hold = 0; tx_hold = 0; begin_test();
        send_bytes(mk_pkt(8'h10, '{32'd5, 32'd7}));
        wait_resp(4);
        tests_run++; if (timed_out) begin tests_failed++; $display("FAIL add_timeout: got 1 expected 0"); end
        tests_run++; if (resp_word() !== 32'h0000_000C) begin tests_failed++; $display("FAIL add_resp: got %h expected 0000000c", resp_word()); end
        tests_run++; if (iss_q.size() != 1) begin tests_failed++; $display("FAIL add_issues: got %0d expected 1", iss_q.size()); end
        else begin
            tests_run++; if (iss_q[0] !== {2'd0, 32'd5, 32'd7}) begin tests_failed++; $display("FAIL add_issue0: got %h expected op0 a5 b7", iss_q[0]); end
        end
    endtask

    task automatic test_div();
        u_hold = 0; tx_hold = 0; begin_test();
        send_bytes(mk_pkt(8'h12, '{32'd100, 32'd5, 32'd2}));
        wait_resp(4);
        tests_run++; if (timed_out) begin tests_failed++; $display("FAIL div_timeout: got 1 expected 0"); end
        tests_run++; if (resp_word() !== 32'h0000_000A) begin tests_failed++; $display("FAIL div_resp: got %h expected 0000000a", resp_word()); end
        tests_run++; if (iss_q.size() != 2) begin tests_failed++; $display("FAIL div_issues: got %0d expected 2", iss_q.size()); end
        else begin
            tests_run++; if (iss_q[0] !== {2'd2, 32'd100, 32'd5}) begin tests_failed++; $display("FAIL div_issue0: got %h expected op2 a100 b5", iss_q[0]); end
            tests_run++; if (iss_q[1] !== {2'd2, 32'd20, 32'd2}) begin tests_failed++; $display("FAIL div_issue1: got %h expected op2 a20 b2", iss_q[1]); end
        end
    endtask

    task automatic test_single_mul();
        u_hold = 0; tx_hold = 0; begin_test();
        send_bytes(mk_pkt(8'h11, '{32'hDEAD_BEEF}));
        wait_resp(4);
        tests_run++; if (timed_out) begin tests_failed++; $display("FAIL mul1_timeout: got 1 expected 0"); end
        tests_run++; if (resp_word() !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL mul1_resp: got %h expected deadbeef", resp_word()); end
        tests_run++; if (iss_q.size() != 0) begin tests_failed++; $display("FAIL mul1_issues: got %0d expected 0", iss_q.size()); end
    endtask

    task automatic test_backpressure();
        u_hold = 20; tx_hold = 5; begin_test();
        send_bytes(mk_pkt(8'h10, '{32'd5, 32'd7}));
        wait_resp(4);
        tests_run++; if (timed_out) begin tests_failed++; $display("FAIL bp_timeout: got 1 expected 0"); end
        tests_run++; if (stab_err != 0) begin tests_failed++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", stab_err); end
        tests_run++; if (resp_word() !== 32'h0000_000C) begin tests_failed++; $display("FAIL bp_resp: got %h expected 0000000c", resp_word()); end
        tests_run++; if (iss_q.size() != 1) begin tests_failed++; $display("FAIL bp_issues: got %0d expected 1", iss_q.size()); end
        u_hold = 0; tx_hold = 0;
    endtask

    task automatic test_malformed();
        u_hold = 0; tx_hold = 0; begin_test();
        send_bytes('{8'h10, 8'h00, 8'h0A, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06});
        wait_resp(0);
        tests_run++; if (timed_out) begin tests_failed++; $display("FAIL mal_accept: got stalled expected all bytes accepted"); end
        tests_run++; if (rx_q.size() != 0 || iss_q.size() != 0) begin tests_failed++; $display("FAIL mal_silent: got %0d bytes %0d issues expected 0 0", rx_q.size(), iss_q.size()); end
        begin_test();
        send_bytes(mk_pkt(8'h10, '{32'd1}));
        wait_resp(4);
        tests_run++; if (resp_word() !== 32'h1) begin tests_failed++; $display("FAIL mal_next: got %h expected 00000001", resp_word()); end
        // LEN below header size drains nothing: next byte is a fresh opcode.
        begin_test();
        send_bytes('{8'h10, 8'h00, 8'h02, 8'h00});
        send_bytes(mk_pkt(8'h11, '{32'h0000_0077}));
        wait_resp(4);
        tests_run++; if (resp_word() !== 32'h77 || timed_out) begin tests_failed++; $display("FAIL short_len: got %h expected 00000077", resp_word()); end
        begin_test();
        send_bytes(mk_pkt(8'h13, '{32'h1234_5678}));
`ifndef ALU_OP_SEQUENCER_ECHO_EN
        send_bytes(mk_pkt(8'hEC, '{32'h0BAD_F00D}));
`endif
        send_bytes(mk_pkt(8'h12, '{32'd9}));
        wait_resp(4);
        tests_run++; if (resp_word() !== 32'd9 || timed_out) begin tests_failed++; $display("FAIL unknown_op: got %h expected 00000009", resp_word()); end
    endtask

    task automatic test_reset_mid();
        int n;
        bq_t p;
        u_hold = 0; tx_hold = 0; begin_test();
        p = mk_pkt(8'h11, '{32'd3, 32'd4});
        send_bytes('{p[0], p[1], p[2], p[3], p[4], p[5]});
        #2 rst_i = 1'b1;
        #1;
        tests_run++; if ({ready_o, valid_o, data_o, unit_v_o, unit_yumi_o, unit_op_o} !== {1'b1, 13'h0}) begin tests_failed++; $display("FAIL rst_opnd_ctl: got %h expected %h", {ready_o, valid_o, data_o, unit_v_o, unit_yumi_o, unit_op_o}, {1'b1, 13'h0}); end
        @(posedge clk_i); #3 rst_i = 1'b0;
        @(posedge clk_i); #1;
        // Reset while the unit is refusing the request.
        u_hold = 1000; begin_test();
        send_bytes(mk_pkt(8'h12, '{32'd100, 32'd5}));
        repeat (3) @(posedge clk_i);
        #1;
        tests_run++; if ({unit_v_o, unit_a_o, unit_b_o} !== {1'b1, 32'd100, 32'd5}) begin tests_failed++; $display("FAIL issue_held: got %h expected v1 a100 b5", {unit_v_o, unit_a_o, unit_b_o}); end
        #2 rst_i = 1'b1;
        #1;
        tests_run++; if ({unit_v_o, unit_a_o, unit_b_o, unit_op_o} !== 67'h0) begin tests_failed++; $display("FAIL rst_issue: got %h expected 0", {unit_v_o, unit_a_o, unit_b_o, unit_op_o}); end
        @(posedge clk_i); #3 rst_i = 1'b0; u_hold = 0;
        @(posedge clk_i); #1;
        // Reset while a response is stalled on the TX side.
        tx_hold = 1000; begin_test();
        send_bytes(mk_pkt(8'h10, '{32'hA5A5_0001}));
        n = 0;
        while (!valid_o && n < 100) begin @(posedge clk_i); #1; n++; end
        tests_run++; if (valid_o !== 1'b1 || data_o !== 8'hA5) begin tests_failed++; $display("FAIL tx_held: got v%b d%h expected v1 da5", valid_o, data_o); end
        #2 rst_i = 1'b1;
        #1;
        tests_run++; if ({valid_o, data_o, ready_o} !== 10'h1) begin tests_failed++; $display("FAIL rst_tx: got %h expected 001", {valid_o, data_o, ready_o}); end
        @(posedge clk_i); #3 rst_i = 1'b0; tx_hold = 0;
        @(posedge clk_i); #1;
        begin_test();
        send_bytes(mk_pkt(8'h10, '{32'd1, 32'd2}));
        wait_resp(4);
        tests_run++; if (resp_word() !== 32'd3 || timed_out) begin tests_failed++; $display("FAIL post_rst: got %h expected 00000003", resp_word()); end
        tests_run++; if (iss_q.size() != 1) begin tests_failed++; $display("FAIL post_rst_issues: got %0d expected 1", iss_q.size()); end
    endtask

    task automatic test_random();
        logic [7:0]  opc;
        logic [1:0]  uop;
        logic [31:0] acc;
        wq_t         w;
        int          nw;
        for (int k = 0; k < 12; k++) begin
            uop = 2'($urandom_range(0, 2));
            opc = 8'h10 + 8'(uop);
            nw  = $urandom_range(1, 4);
            w.delete();
            for (int i = 0; i < nw; i++)
                w.push_back((opc == 8'h12 && i > 0) ? 32'($urandom_range(1, 300)) : 32'($urandom));
            u_hold = $urandom_range(0, 3); tx_hold = $urandom_range(0, 2);
            begin_test();
            send_bytes(mk_pkt(opc, w));
            wait_resp(4);
            tests_run++; if (resp_word() !== fold_ref(opc, w) || timed_out) begin tests_failed++; $display("FAIL rand_resp[%0d]: got %h expected %h", k, resp_word(), fold_ref(opc, w)); end
            tests_run++; if (iss_q.size() != nw - 1) begin tests_failed++; $display("FAIL rand_issues[%0d]: got %0d expected %0d", k, iss_q.size(), nw - 1); end
            acc = w[0];
            for (int i = 1; i < nw && i <= iss_q.size(); i++) begin
                tests_run++; if (iss_q[i-1] !== {uop, acc, w[i]}) begin tests_failed++; $display("FAIL rand_issue[%0d.%0d]: got %h expected %h", k, i, iss_q[i-1], {uop, acc, w[i]}); end
                if (uop == 2'd0)      acc = acc + w[i];
                else if (uop == 2'd1) acc = acc * w[i];
                else                  acc = acc / w[i];
            end
            tests_run++; if (stab_err != 0) begin tests_failed++; $display("FAIL rand_stable[%0d]: got %0d expected 0", k, stab_err); end
        end
        u_hold = 0; tx_hold = 0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_div();
        test_single_mul();
        test_backpressure();
        test_malformed();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
